// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: synchronises and de-glitches the bus,
// deserialises 11-bit frames and strobes out one byte with parity/stop status.
module ps2_rx_frame #(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2d,
    input  logic       ps2c,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CW = 4;
    localparam int unsigned FW = 10;

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    logic                  r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_fclk;
    logic                  w_fall;

    state_t                r_state, w_state_next;
    logic [CW-1:0]         r_bcnt, w_bcnt_next;
    logic [TW-1:0]         r_tmo, w_tmo_next;
    logic [FW-1:0]         r_shreg, w_shreg_next, w_frame;
    logic [7:0]            r_dout, w_dout_next;
    logic                  r_perr, w_perr_next;
    logic                  r_ferr, w_ferr_next;
    logic                  r_tick, w_tick_next;

    // Two-flop synchronisers and ps2c de-glitch filter; bus idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c_meta <= 1'b1;
            r_c_sync <= 1'b1;
            r_d_meta <= 1'b1;
            r_d_sync <= 1'b1;
            r_filt   <= '1;
            r_fclk   <= 1'b1;
        end else begin
            r_c_meta <= ps2c;
            r_c_sync <= r_c_meta;
            r_d_meta <= ps2d;
            r_d_sync <= r_d_meta;
            r_filt   <= {r_c_sync, r_filt[FILTER_LEN-1:1]};
            if (&r_filt) begin
                r_fclk <= 1'b1;
            end else if (~|r_filt) begin
                r_fclk <= 1'b0;
            end
        end
    end

    assign w_fall = r_fclk & ~(|r_filt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_tmo   <= '0;
            r_shreg <= '0;
            r_dout  <= 8'h00;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
            r_tmo   <= w_tmo_next;
            r_shreg <= w_shreg_next;
            r_dout  <= w_dout_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
            r_tick  <= w_tick_next;
        end
    end

    // Next-state logic; byte and flags load on the stop-bit edge so they are
    // valid in the same cycle as the strobe
    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        w_tmo_next   = r_tmo;
        w_shreg_next = r_shreg;
        w_dout_next  = r_dout;
        w_perr_next  = r_perr;
        w_ferr_next  = r_ferr;
        w_tick_next  = 1'b0;
        w_frame      = {r_d_sync, r_shreg[FW-1:1]};
        case (r_state)
            IDLE: begin
                if (w_fall && rx_en && !r_d_sync) begin
                    w_state_next = RECV;
                    w_bcnt_next  = CW'(10);
                    w_tmo_next   = '0;
                end
            end
            RECV: begin
                if (w_fall) begin
                    w_shreg_next = w_frame;
                    w_bcnt_next  = r_bcnt - CW'(1);
                    w_tmo_next   = '0;
                    if (r_bcnt == CW'(1)) begin
                        w_state_next = DONE;
                        w_tick_next  = 1'b1;
                        w_dout_next  = w_frame[7:0];
                        w_perr_next  = ~(^w_frame[8:0]);
                        w_ferr_next  = ~w_frame[9];
                    end
                end else if (r_tmo >= TW'(TIMEOUT_CYC - 1)) begin
                    w_state_next = IDLE;
                end else begin
                    w_tmo_next = r_tmo + TW'(1);
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign rx_done_tick = r_tick;
    assign dout         = r_dout;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;

endmodule
